// File: rtl/bus_decoder_mmu.sv
// 6502 system address decoder with a 16-entry page-mapping unit and an RDY wait-state FSM.
// Optional write protection of mapped pages is enabled by defining MMU_WRITE_PROTECT_EN.
module bus_decoder_mmu #(
    parameter int unsigned       NUM_IO      = 9,
    parameter logic [15:0]       IO_BASE     = 16'hFE00,
    parameter logic [15:0]       ROM_BASE    = 16'hE000,
    parameter int unsigned       PHYS_BITS   = 20,
    parameter logic [NUM_IO-1:0] WAIT_MASK   = '0,
    parameter int unsigned       WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 R_W_n,
    input  logic [15:0]          addr_i,
    input  logic [15:0]          addr_w_i,
    input  logic [7:0]           data_i,
    output logic [7:0]           data_o,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [PHYS_BITS-1:0] ram_addr_o,
    output logic                 rom_cs,
    output logic                 addr_dec_cs,
    output logic [NUM_IO-1:0]    io_cs,
    output logic                 rdy_o
`ifdef MMU_WRITE_PROTECT_EN
    ,
    output logic                 wp_fault_o
`endif
);

    localparam int unsigned      E        = PHYS_BITS - 12;
    localparam int unsigned      CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 1) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       NUM_IO_B = 8'(NUM_IO);
    localparam logic [16:0]      IO_LAST  = {1'b0, IO_BASE} + 17'h000FF;
    localparam bit               WAITS_ON = (WAIT_CYCLES > 0);

    logic                 wr_en;
    logic [7:0]           io_bank_l_q, io_bank_l_d;
    logic [7:0]           io_bank_h_q, io_bank_h_d;
    logic [7:0]           rom_sel_q,   rom_sel_d;
    logic [15:0][E-1:0]   map_w;

    assign wr_en = ~R_W_n;

    always_comb begin
        io_bank_l_d = io_bank_l_q;
        io_bank_h_d = io_bank_h_q;
        rom_sel_d   = rom_sel_q;
        if (wr_en && addr_i == 16'h0000) io_bank_l_d = data_i;
        if (wr_en && addr_i == 16'h0001) io_bank_h_d = data_i;
        if (wr_en && addr_i == 16'h0002) rom_sel_d   = data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            io_bank_l_q <= '0;
            io_bank_h_q <= '0;
            rom_sel_q   <= '0;
        end else begin
            io_bank_l_q <= io_bank_l_d;
            io_bank_h_q <= io_bank_h_d;
            rom_sel_q   <= rom_sel_d;
        end
    end

    // Page map resets to identity so the CPU sees a flat 64K view before software sets it up.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_map
            logic [E-1:0] entry_q;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i)
                    entry_q <= E'(gi);
                else if (wr_en && addr_i == (16'h0010 + 16'(gi)))
                    entry_q <= data_i[E-1:0];
            end
            assign map_w[gi] = entry_q;
        end
    endgenerate

`ifdef MMU_WRITE_PROTECT_EN
    logic [15:0] wp_mask_q, wp_mask_d;
    logic        wp_fault_q, wp_fault_d;
`endif

    logic       dec_hit;
    logic [7:0] reg_rdata;

    always_comb begin
        dec_hit   = 1'b0;
        reg_rdata = '0;
        case (addr_w_i)
            16'h0000: begin dec_hit = 1'b1; reg_rdata = io_bank_l_q; end
            16'h0001: begin dec_hit = 1'b1; reg_rdata = io_bank_h_q; end
            16'h0002: begin dec_hit = 1'b1; reg_rdata = rom_sel_q;   end
`ifdef MMU_WRITE_PROTECT_EN
            16'h0020: begin dec_hit = 1'b1; reg_rdata = wp_mask_q[7:0];  end
            16'h0021: begin dec_hit = 1'b1; reg_rdata = wp_mask_q[15:8]; end
            16'h0022: begin dec_hit = 1'b1; reg_rdata = {7'b0, wp_fault_q}; end
`endif
            default: begin
                if (addr_w_i[15:4] == 12'h001) begin
                    dec_hit   = 1'b1;
                    reg_rdata = 8'(map_w[addr_w_i[3:0]]);
                end
            end
        endcase
    end

    logic in_io, in_rom, bank_zero, bank_dev, io_sel, rom_hit, ram_hit, ram_wr;

    assign in_io     = ({1'b0, addr_w_i} >= {1'b0, IO_BASE}) && ({1'b0, addr_w_i} <= IO_LAST);
    assign in_rom    = (addr_w_i >= ROM_BASE) && (addr_w_i != 16'hFFFF);
    assign bank_zero = (io_bank_l_q == 8'h00);
    assign bank_dev  = !bank_zero && (io_bank_l_q < NUM_IO_B);

    // Priority: decoder registers, then the I/O window, then ROM, with RAM as the fallback.
    assign io_sel  = !dec_hit && in_io && bank_dev;
    assign rom_hit = !dec_hit && ((in_io && bank_zero) || (!in_io && in_rom && rom_sel_q == 8'h00));
    assign ram_hit = !(dec_hit || io_sel || rom_hit);
    assign ram_wr  = ram_hit && wr_en;

    assign addr_dec_cs = dec_hit;
    assign rom_cs      = rom_hit;
    assign ram_cs      = ram_hit;
    assign data_o      = reg_rdata;
    assign ram_addr_o  = {map_w[addr_w_i[15:12]], addr_w_i[11:0]};

    assign io_cs[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_IO; gi++) begin : g_io_cs
            assign io_cs[gi] = io_sel && (io_bank_l_q == 8'(gi));
        end
    endgenerate

`ifdef MMU_WRITE_PROTECT_EN
    logic page_prot;
    assign page_prot = wp_mask_q[addr_w_i[15:12]];

    // A protected write in the same cycle as a clear still leaves the fault flagged.
    always_comb begin
        wp_mask_d  = wp_mask_q;
        wp_fault_d = wp_fault_q;
        if (wr_en && addr_i == 16'h0020) wp_mask_d[7:0]  = data_i;
        if (wr_en && addr_i == 16'h0021) wp_mask_d[15:8] = data_i;
        if (wr_en && addr_i == 16'h0022) wp_fault_d      = 1'b0;
        if (ram_wr && page_prot)         wp_fault_d      = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_mask_q  <= '0;
            wp_fault_q <= 1'b0;
        end else begin
            wp_mask_q  <= wp_mask_d;
            wp_fault_q <= wp_fault_d;
        end
    end

    assign ram_we     = ram_wr && !page_prot;
    assign wp_fault_o = wp_fault_q;
`else
    assign ram_we = ram_wr;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             slow_hit, start_wait;

    assign slow_hit   = |(io_cs & WAIT_MASK);
    assign start_wait = (state_q == ST_IDLE) && slow_hit && WAITS_ON;

    // DONE always gives one RDY-high cycle so a held slow address cannot stall forever.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_wait) begin
                        if (WAIT_CYCLES == 1) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdy_o = ~(start_wait || (state_q == ST_WAIT));

endmodule

// File: tb/tb_bus_decoder_mmu.sv
// Directed self-checking bench for bus_decoder_mmu (slow device 3, three wait cycles).
// Covers decode priority, page mapping, RDY stall timing and, when MMU_WRITE_PROTECT_EN is defined, page protection.
module tb_bus_decoder_mmu;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        R_W_n;
    logic [15:0] addr_i;
    logic [15:0] addr_w_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        ram_cs;
    logic        ram_we;
    logic [19:0] ram_addr_o;
    logic        rom_cs;
    logic        addr_dec_cs;
    logic [8:0]  io_cs;
    logic        rdy_o;
`ifdef MMU_WRITE_PROTECT_EN
    logic        wp_fault_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bus_decoder_mmu #(
        .NUM_IO      (9),
        .IO_BASE     (16'hFE00),
        .ROM_BASE    (16'hE000),
        .PHYS_BITS   (20),
        .WAIT_MASK   (9'h008),
        .WAIT_CYCLES (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .R_W_n       (R_W_n),
        .addr_i      (addr_i),
        .addr_w_i    (addr_w_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_addr_o  (ram_addr_o),
        .rom_cs      (rom_cs),
        .addr_dec_cs (addr_dec_cs),
        .io_cs       (io_cs),
        .rdy_o       (rdy_o)
`ifdef MMU_WRITE_PROTECT_EN
        ,
        .wp_fault_o  (wp_fault_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_i);
        addr_i   = a;
        addr_w_i = a;
        data_i   = d;
        R_W_n    = 1'b0;
        @(negedge clk_i);
        R_W_n    = 1'b1;
        $display("write  addr=%h data=%h", a, d);
    endtask

    task automatic look(input logic [15:0] a);
        @(negedge clk_i);
        addr_i   = a;
        addr_w_i = a;
        R_W_n    = 1'b1;
        #1;
        $display("read   addr=%h data_o=%h ram=%b rom=%b dec=%b io=%b rdy=%b",
                 a, data_o, ram_cs, rom_cs, addr_dec_cs, io_cs, rdy_o);
    endtask

    // cs vector packed as {ram, rom, dec, io[8:0]}
    function automatic logic [11:0] cs_vec();
        return {ram_cs, rom_cs, addr_dec_cs, io_cs};
    endfunction

    initial begin
        rst_n_i  = 1'b0;
        R_W_n    = 1'b1;
        addr_i   = 16'h3ABC;
        addr_w_i = 16'h3ABC;
        data_i   = 8'h00;
        #1;
        check_eq("rst_rdy", rdy_o, 1);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Identity map after reset
        for (int i = 0; i < 16; i++) begin
            look(16'h0010 + 16'(i));
            check_eq("map_reset_rd", data_o, i);
        end
        check_eq("map_dec_cs", addr_dec_cs, 1);
        look(16'h0000);
        check_eq("bank_l_reset", data_o, 8'h00);
        look(16'h3ABC);
        check_eq("flat_cs", cs_vec(), 12'h800);
        check_eq("flat_addr", ram_addr_o, 20'h03ABC);
        check_eq("flat_data0", data_o, 8'h00);

        // Remap page 3
        bus_write(16'h0013, 8'hA5);
        look(16'h3123);
        check_eq("remap_addr", ram_addr_o, 20'hA5123);
        check_eq("remap_we_rd", ram_we, 0);
        @(negedge clk_i);
        R_W_n = 1'b0;
        #1;
        check_eq("remap_we_wr", ram_we, 1);
        look(16'h0013);
        check_eq("map3_rd", data_o, 8'hA5);

        // I/O window banking
        bus_write(16'h0000, 8'h04);
        look(16'hFE10);
        check_eq("io4_cs", cs_vec(), 12'h010);
        check_eq("io4_rdy", rdy_o, 1);
        check_eq("io4_we", ram_we, 0);
        look(16'h0000);
        check_eq("bank_l_rd", data_o, 8'h04);
        bus_write(16'h0000, 8'h08);
        look(16'hFEFF);
        check_eq("io8_cs", cs_vec(), 12'h100);
        bus_write(16'h0000, 8'h09);
        look(16'hFE10);
        check_eq("bank_numio_ram", cs_vec(), 12'h800);
        bus_write(16'h0000, 8'h20);
        look(16'hFE10);
        check_eq("bank20_ram", cs_vec(), 12'h800);
        bus_write(16'h0000, 8'h00);
        look(16'hFE10);
        check_eq("bank0_rom", cs_vec(), 12'h400);
        look(16'hFDFF);
        check_eq("below_io_rom", cs_vec(), 12'h400);

        // ROM window and rom_sel
        look(16'hE000);
        check_eq("rom_base", cs_vec(), 12'h400);
        look(16'hFFFE);
        check_eq("rom_top", cs_vec(), 12'h400);
        look(16'hFFFF);
        check_eq("ffff_ram", cs_vec(), 12'h800);
        check_eq("ffff_addr", ram_addr_o, 20'h0FFFF);
        look(16'hDFFF);
        check_eq("dfff_ram", cs_vec(), 12'h800);
        bus_write(16'h0002, 8'h01);
        look(16'hE000);
        check_eq("romsel_ram", cs_vec(), 12'h800);
        look(16'hFFFF);
        check_eq("romsel_ffff", cs_vec(), 12'h800);
        look(16'h0002);
        check_eq("romsel_rd", data_o, 8'h01);
        look(16'h0003);
        check_eq("gap_ram", cs_vec(), 12'h800);
`ifndef MMU_WRITE_PROTECT_EN
        look(16'h0020);
        check_eq("wp_off_ram", cs_vec(), 12'h800);
        check_eq("wp_off_data", data_o, 8'h00);
`endif

        // Wait states: device 3 is slow, three cycles low then one high, repeating while held
        bus_write(16'h0000, 8'h03);
        check_eq("pre_wait_rdy", rdy_o, 1);
        look(16'hFE00);
        check_eq("io3_cs", cs_vec(), 12'h008);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk_i);
                #1;
            end
            check_eq($sformatf("rdy_c%0d", c), rdy_o, (c % 4 == 3) ? 1 : 0);
        end
        @(negedge clk_i);
        #1;
        check_eq("rdy_stall3", rdy_o, 0);
        rst_n_i = 1'b0;
        #1;
        check_eq("rdy_async_rst", rdy_o, 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        look(16'h3123);
        check_eq("rst_map_restore", ram_addr_o, 20'h03123);

`ifdef MMU_WRITE_PROTECT_EN
        check_eq("wp_reset", wp_fault_o, 0);
        bus_write(16'h0020, 8'h04);
        look(16'h0020);
        check_eq("wp_mask_rd", data_o, 8'h04);
        @(negedge clk_i);
        addr_i   = 16'h2000;
        addr_w_i = 16'h2000;
        R_W_n    = 1'b0;
        #1;
        check_eq("wp_we_blocked", ram_we, 0);
        check_eq("wp_ram_cs", ram_cs, 1);
        look(16'h3000);
        check_eq("wp_fault_set", wp_fault_o, 1);
        bus_write(16'h0022, 8'h00);
        #1;
        check_eq("wp_fault_clr", wp_fault_o, 0);
        @(negedge clk_i);
        addr_i   = 16'h3000;
        addr_w_i = 16'h3000;
        R_W_n    = 1'b0;
        #1;
        check_eq("wp_unprot_we", ram_we, 1);
        look(16'h3000);
        check_eq("wp_no_fault", wp_fault_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
